// File: rtl/alb_unit_pkg.sv
// Shared op-codes and default width for the ALB unit.
package alb_unit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // ALB_MI encoding
  typedef enum logic [1:0] {
    OP_SUB = 2'b00,
    OP_AND = 2'b01,
    OP_ADD = 2'b10,
    OP_OR  = 2'b11
  } alb_op_e;

endpackage : alb_unit_pkg

// File: rtl/alb_unit_if.sv
// Operand/op-select inputs and registered result/flags of the ALB unit.
interface alb_unit_if
  import alb_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] R_in;
  logic [WIDTH-1:0] S_in;
  logic             CI_in;
  logic [1:0]       ALB_MI;
  logic [WIDTH-1:0] F;
  logic             CO;
  logic             ZO;
  logic             NO;
  logic             VO;

  modport master (
    output R_in, S_in, CI_in, ALB_MI,
    input  F, CO, ZO, NO, VO
  );

  modport slave (
    input  R_in, S_in, CI_in, ALB_MI,
    output F, CO, ZO, NO, VO
  );

endinterface : alb_unit_if

// File: rtl/alb_datapath.sv
// Combinational ALB datapath: next result and flags for the selected op.
module alb_datapath
  import alb_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic             ci,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] f_c,
  output logic             co_c,
  output logic             zo_c,
  output logic             no_c,
  output logic             vo_c
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH:0]   sum;

  // SUB adds the inverted S operand; carry-in completes the two's complement
  always_comb begin
    s_eff = (op == OP_SUB) ? ~s : s;
    sum   = {1'b0, r} + {1'b0, s_eff} + (WIDTH+1)'(ci);
  end

  // Result select and flag generation
  always_comb begin
    f_c  = '0;
    co_c = 1'b0;
    vo_c = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        f_c  = sum[WIDTH-1:0];
        co_c = sum[WIDTH];
        vo_c = (r[MSB] == s_eff[MSB]) && (sum[MSB] != r[MSB]);
      end
      OP_AND: f_c = r & s;
      OP_OR:  f_c = r | s;
      default: ;
    endcase
    zo_c = (f_c == '0);
    no_c = f_c[MSB];
  end

endmodule : alb_datapath

// File: rtl/alb_unit.sv
// ALB unit top: async-reset output registers around the combinational datapath.
module alb_unit
  import alb_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       resetb,
  alb_unit_if.slave  bus
);

  logic [WIDTH-1:0] f_c;
  logic             co_c;
  logic             zo_c;
  logic             no_c;
  logic             vo_c;

  logic [WIDTH-1:0] f_q;
  logic             co_q;
  logic             zo_q;
  logic             no_q;
  logic             vo_q;

  alb_datapath #(.WIDTH(WIDTH)) u_datapath (
    .r    (bus.R_in),
    .s    (bus.S_in),
    .ci   (bus.CI_in),
    .op   (bus.ALB_MI),
    .f_c  (f_c),
    .co_c (co_c),
    .zo_c (zo_c),
    .no_c (no_c),
    .vo_c (vo_c)
  );

  // Output registers; resetb is active-high and clears everything, ZO included
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      f_q  <= '0;
      co_q <= 1'b0;
      zo_q <= 1'b0;
      no_q <= 1'b0;
      vo_q <= 1'b0;
    end else begin
      f_q  <= f_c;
      co_q <= co_c;
      zo_q <= zo_c;
      no_q <= no_c;
      vo_q <= vo_c;
    end
  end

  assign bus.F  = f_q;
  assign bus.CO = co_q;
  assign bus.ZO = zo_q;
  assign bus.NO = no_q;
  assign bus.VO = vo_q;

endmodule : alb_unit

// File: tb/tb_alb_unit.sv
// Testbench for alb_unit: directed vectors, async reset, and random run vs a behavioural model.
module tb_alb_unit;
  import alb_unit_pkg::*;

  localparam int unsigned W = 8;

  logic clk    = 1'b0;
  logic resetb = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  bit cmp_en = 1'b0;

  // Model outputs for the current cycle
  int exp_f  = 0;
  int exp_co = 0;
  int exp_zo = 0;
  int exp_no = 0;
  int exp_vo = 0;

  alb_unit_if #(.WIDTH(W)) bus ();

  alb_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic int sgn8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Behavioural model: integer arithmetic on the inputs seen at the edge
  always @(posedge clk or posedge resetb) begin
    int r, s, ci, t, sv;
    if (resetb) begin
      exp_f = 0; exp_co = 0; exp_zo = 0; exp_no = 0; exp_vo = 0;
    end else begin
      r  = int'(bus.R_in);
      s  = int'(bus.S_in);
      ci = int'(bus.CI_in);
      t  = 0;
      sv = 0;
      case (bus.ALB_MI)
        2'b10: begin t = r + s + ci;         sv = sgn8(r) + sgn8(s) + ci;     end
        2'b00: begin t = r + (255 - s) + ci; sv = sgn8(r) - sgn8(s) - 1 + ci; end
        2'b01: t = r & s;
        default: t = r | s;
      endcase
      exp_f  = t % 256;
      exp_co = (bus.ALB_MI[0] == 1'b0 && t > 255) ? 1 : 0;
      exp_vo = (bus.ALB_MI[0] == 1'b0 && (sv > 127 || sv < -128)) ? 1 : 0;
      exp_zo = (exp_f == 0) ? 1 : 0;
      exp_no = (exp_f >= 128) ? 1 : 0;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (cmp_en)
      chk("cycle", int'({bus.F, bus.CO, bus.ZO, bus.NO, bus.VO}),
          (exp_f << 4) | (exp_co << 3) | (exp_zo << 2) | (exp_no << 1) | exp_vo);
  end

  task automatic drive(input logic [1:0] op, input int r, input int s, input logic ci);
    @(negedge clk);
    bus.ALB_MI = op;
    bus.R_in   = W'(r);
    bus.S_in   = W'(s);
    bus.CI_in  = ci;
  endtask

  // Check DUT and model against hand-computed values one cycle after drive
  task automatic expect_lit(input string name, input int f, input int co, input int zo,
                            input int no, input int vo);
    @(posedge clk);
    #1;
    chk({name, ".F"},  int'(bus.F),  f);
    chk({name, ".CO"}, int'(bus.CO), co);
    chk({name, ".ZO"}, int'(bus.ZO), zo);
    chk({name, ".NO"}, int'(bus.NO), no);
    chk({name, ".VO"}, int'(bus.VO), vo);
    chk({name, ".model"}, (exp_f << 4) | (exp_co << 3) | (exp_zo << 2) | (exp_no << 1) | exp_vo,
        (f << 4) | (co << 3) | (zo << 2) | (no << 1) | vo);
  endtask

  initial begin
    bus.ALB_MI = 2'b10;
    bus.R_in   = '0;
    bus.S_in   = '0;
    bus.CI_in  = 1'b0;

    // Async reset before any clock edge
    #1 resetb = 1'b1;
    #2;
    chk("rst.F",  int'(bus.F),  0);
    chk("rst.ZO", int'(bus.ZO), 0);
    chk("rst.flags", int'({bus.CO, bus.NO, bus.VO}), 0);
    cmp_en = 1'b1;
    drive(OP_ADD, 8'h12, 8'h34, 1'b0);
    @(negedge clk);
    chk("rst.held", int'({bus.F, bus.ZO}), 0);
    resetb = 1'b0;

    // First edge after release produces the result of the pending inputs
    expect_lit("first", 8'h46, 0, 0, 0, 0);

    drive(OP_ADD, 8'h7F, 8'h01, 1'b0);  expect_lit("add_ovf",   8'h80, 0, 0, 1, 1);
    drive(OP_ADD, 8'hFF, 8'h01, 1'b1);  expect_lit("add_carry", 8'h01, 1, 0, 0, 0);
    drive(OP_SUB, 8'h05, 8'h05, 1'b1);  expect_lit("sub_zero",  8'h00, 1, 1, 0, 0);
    drive(OP_SUB, 8'h80, 8'h01, 1'b1);  expect_lit("sub_ovf",   8'h7F, 1, 0, 0, 1);
    drive(OP_SUB, 8'h03, 8'h05, 1'b1);  expect_lit("sub_borrow",8'hFE, 0, 0, 1, 0);
    drive(OP_AND, 8'hF0, 8'h3C, 1'b1);  expect_lit("and",       8'h30, 0, 0, 0, 0);
    drive(OP_OR,  8'h0F, 8'hF0, 1'b0);  expect_lit("or",        8'hFF, 0, 0, 1, 0);
    drive(OP_AND, 8'hAA, 8'h55, 1'b1);  expect_lit("and_zero",  8'h00, 0, 1, 0, 0);
    drive(OP_ADD, 8'hFF, 8'h00, 1'b1);  expect_lit("add_wrap",  8'h00, 1, 1, 0, 0);

    // Reset asserted between edges during an ADD stream
    drive(OP_ADD, 8'h20, 8'h22, 1'b0);
    drive(OP_ADD, 8'h30, 8'h33, 1'b1);
    #2 resetb = 1'b1;
    #1;
    chk("midrst.F", int'(bus.F), 0);
    chk("midrst.flags", int'({bus.CO, bus.ZO, bus.NO, bus.VO}), 0);
    drive(OP_ADD, 8'h10, 8'h20, 1'b0);
    chk("midrst.discard", int'(bus.F), 0);
    resetb = 1'b0;
    expect_lit("after_rst", 8'h30, 0, 0, 0, 0);

    // Random run: every input changes every cycle
    for (int i = 0; i < 10000; i++)
      drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_alb_unit
